uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

UART transmit engine that drains the transmit-side `sync_fifo` and serializes each byte onto the `tx` line. It is the reader end of the TX FIFO: it issues single-cycle `read_req` pulses only when the FIFO reports non-empty, and captures the registered FIFO output one cycle later. It then shifts out an 8N1 frame, or 8E1 with parity, at a fixed clocks-per-bit rate. Sits between the TX `sync_fifo` and the chip-level `tx` pin.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Legal values are ≥ 2.
- `DATA_WIDTH`, default 8: byte width. Must match the FIFO `DATA_WIDTH`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid the cycle after `fifo_rd_req` is high.
- `fifo_rd_req`  out  1  FIFO `read_req`; registered; high for exactly one cycle per byte.
- `tx`  out  1  serial line; idle high; registered.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation

- Reset values: `tx`=1, `fifo_rd_req`=0, `busy`=0, `tx_done`=0. State is IDLE and all counters are 0.
- Assertion of `reset` at any time forces these values asynchronously. A frame in flight is abandoned. The byte already read from the FIFO is lost and is not re-read.
- State machine:
  - IDLE → FETCH when `fifo_empty`=0 at a clock edge. Otherwise stay in IDLE with `tx`=1.
  - FETCH (1 cycle): `fifo_rd_req`=1. → LOAD.
  - LOAD (1 cycle): `fifo_data` is valid and is latched into the shift register at the end of the cycle. → START.
  - START: `tx`=0 for CLKS_PER_BIT cycles. → DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit index 0..7. After bit 7 → PARITY if enabled, else → STOP.
  - PARITY (only with the macro): `tx` = XOR of the latched byte (even parity), held CLKS_PER_BIT cycles. → STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. `tx_done`=1 on its final cycle. → IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, clears on every bit boundary, and is held at 0 in IDLE, FETCH and LOAD.
- `fifo_empty` is sampled only in IDLE. Changes to it mid-frame have no effect.
- `fifo_rd_req` is never asserted while `fifo_empty`=1. This follows structurally from sampling `fifo_empty` only in IDLE.
- The block never writes the FIFO and never drives `read_req` in consecutive cycles.

## Timing

- FIFO read latency is 1 cycle: `fifo_rd_req` high in cycle N, and `fifo_data` is valid in cycle N+1.
- Latency from the first edge that samples `fifo_empty`=0 in IDLE to the start bit appearing on `tx` is 3 cycles (FETCH, LOAD, then START).
- Frame length from the first START cycle to the last STOP cycle:
  - 10·CLKS_PER_BIT cycles without parity.
  - 11·CLKS_PER_BIT cycles with parity.
- Back-to-back bytes: the gap between the last STOP cycle and the next START cycle is exactly 3 idle-high cycles (IDLE, FETCH, LOAD).
- `busy` rises the cycle after IDLE exits, i.e. in FETCH. It falls in the first IDLE cycle after STOP.

## Configuration

- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. An even-parity bit is inserted between data bit 7 and the stop bit, and the frame is 11 bits.
- `UART_TX_PARITY_EN` undefined: the PARITY state and its XOR logic are absent, and the frame is 8N1 (10 bits).

## Test plan

- **Reset:** hold `reset`=1 for 2 cycles with `fifo_empty`=0 → `tx`=1, `fifo_rd_req`=0, `busy`=0, `tx_done`=0 throughout.
- **Single byte:** CLKS_PER_BIT=4, FIFO holds 0xA5.
  - Required response: `fifo_rd_req` high for exactly one cycle.
  - `tx` shows 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
  - `tx_done` pulses once, at cycle 40 of the frame.
- **Back-to-back:** FIFO holds 0x5A then 0xFF.
  - Required response: two frames on `tx`.
  - Exactly 3 high cycles between the stop bit of 0x5A and the start bit of 0xFF.
  - Exactly two `fifo_rd_req` pulses, then `fifo_empty`=1 and IDLE.
- **Empty FIFO:** `fifo_empty`=1 for 200 cycles → no `fifo_rd_req`, `tx`=1, `busy`=0.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0xCC.
  - Required response: `tx`=1 and `busy`=0 immediately, with no `tx_done`.
  - After release, the next FIFO byte (0x00) is fetched and sent as a complete frame.
- **Parity** (with `UART_TX_PARITY_EN`): 0xA5 → parity bit 0; 0x07 → parity bit 1. Each frame is 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// FIFO read-side bundle between the TX sync_fifo and the UART transmit engine.
// master = engine (reader), slave = FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_req;

    modport master (input fifo_empty, input fifo_data, output fifo_rd_req);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd_req);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmit engine: pops one byte at a time from the TX FIFO and shifts it out as 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           tx_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic tx_d, busy_d, tx_done_d, rd_req_d;
    logic rd_req_q;

    logic bit_end_c;
    assign bit_end_c = (baud_q == BAUD_LAST);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    // Next-state, baud counter and bit index
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo.fifo_empty) state_d = FETCH;
            end
            FETCH: begin
                baud_d  = '0;
                state_d = LOAD;
            end
            LOAD: begin
                baud_d  = '0;
                data_d  = fifo.fifo_data;
                state_d = START;
            end
            START: begin
                baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
                if (bit_end_c) state_d = DATA;
            end
            DATA: begin
                baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
                if (bit_end_c) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
                if (bit_end_c) state_d = STOP;
            end
`endif
            STOP: begin
                baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
                if (bit_end_c) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the upcoming state so the registered copies line up with state_q
    always_comb begin
        tx_d      = 1'b1;
        busy_d    = (state_d != IDLE);
        rd_req_d  = (state_d == FETCH);
        tx_done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = ^data_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            rd_req_q <= 1'b0;
        end else begin
            tx       <= tx_d;
            busy     <= busy_d;
            tx_done  <= tx_done_d;
            rd_req_q <= rd_req_d;
        end
    end

    assign fifo.fifo_rd_req = rd_req_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a FIFO model feeds bytes, a negedge monitor decodes tx cycle by cycle.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int LEN = FB * CPB;

    logic clk = 1'b0;
    logic reset;
    logic tx, busy, tx_done;

    uart_tx_fifo_if #(.DATA_WIDTH(8)) fif ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .fifo    (fif.master),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model with one-cycle registered read
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [7:0] exp_q [$];

    assign fif.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fif.fifo_rd_req && (rd_ptr != wr_ptr)) begin
            fif.fifo_data <= mem[rd_ptr[5:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Line monitor
    int         c = 0;
    bit         in_frame = 0;
    bit         after_stop = 0;
    bit         prev_rd = 0;
    int         gap = 0;
    int         gap_frame = -1;
    int         frames_done = 0;
    int         rd_cnt = 0;
    logic [7:0] cur;
    logic [10:0] bits;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_done", tx_done, 0);
            check("rst_rd", fif.fifo_rd_req, 0);
            in_frame   = 0;
            after_stop = 0;
            prev_rd    = 0;
        end else begin
            if (fif.fifo_rd_req) begin
                rd_cnt++;
                check("rd_consec", prev_rd, 0);
                check("rd_when_empty", fif.fifo_empty, 0);
            end
            prev_rd = fif.fifo_rd_req;
            if (after_stop) begin
                check("busy_fall", busy, 0);
                after_stop = 0;
            end
            if (!in_frame && tx == 1'b0) begin
                check("frame_expected", int'(exp_q.size() > 0), 1);
                cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                if (frames_done == gap_frame) check("gap", gap, 3);
                bits = '1;
                bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) bits[1+i] = cur[i];
`ifdef UART_TX_PARITY_EN
                bits[9] = ^cur;
`endif
                in_frame = 1;
                c = 0;
            end
            if (in_frame) begin
                check("tx_bit", tx, bits[c / CPB]);
                check("tx_done", tx_done, int'(c == LEN - 1));
                check("busy_frame", busy, 1);
                c++;
                if (c == LEN) begin
                    in_frame   = 0;
                    frames_done++;
                    gap        = 0;
                    after_stop = 1;
                end
            end else begin
                gap++;
                check("idle_done", tx_done, 0);
            end
        end
    end

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_done < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check("frames_reached", frames_done, n);
    endtask

    int r0;
    int nb;
    int k;

    initial begin
        reset = 1'b1;
        push(8'hA5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single byte
        r0 = rd_cnt;
        wait_frames(1);
        check("rd_single", rd_cnt - r0, 1);

        // back-to-back
        repeat (5) @(negedge clk);
        gap_frame = 2;
        r0 = rd_cnt;
        push(8'h5A);
        push(8'hFF);
        wait_frames(3);
        repeat (3) @(posedge clk);
        check("rd_b2b", rd_cnt - r0, 2);
        check("b2b_empty", fif.fifo_empty, 1);
        check("b2b_idle", busy, 0);
        gap_frame = -1;

        // empty FIFO
        r0 = rd_cnt;
        nb = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy || !tx) nb++;
        end
        check("empty_rd", rd_cnt - r0, 0);
        check("empty_active", nb, 0);

        // reset during data bit 3
        push(8'hCC);
        push(8'h00);
        k = 0;
        while (!(in_frame && c == 17) && k < 500) begin
            @(posedge clk);
            k++;
        end
        check("reach_bit3", int'(in_frame && c == 17), 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", tx_done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_frames(4);

        // parity patterns (plain 8N1 frames when parity is compiled out)
        push(8'hA5);
        push(8'h07);
        wait_frames(6);
        repeat (3) @(posedge clk);
        check("exp_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
